vga_sync_decoder: RTL
=====================

Name: vga_sync_decoder

Overview:
- Receiving end of the VGA timing interface: samples the hs/vs/display strobes driven by the VGA controller and reconstructs pixel coordinates, frame markers and a lock status.
- Used as a self-check and capture front end. Sprite and background debug logic and the on-screen-capture path index by its recovered X/Y instead of trusting DrawX/DrawY.
- Single Clk domain. Sampling is qualified by a pixel-rate enable.

Parameters:
- H_VISIBLE, 640, display pixels per line
- H_TOTAL, 800, pixel periods per line (hs fall to hs fall)
- V_VISIBLE, 480, display lines per frame
- V_TOTAL, 525, lines per frame (hs falls between vs falls)
- LOCK_FRAMES, 2, consecutive good frames required to assert locked

Ports:
- Clk  in  1  system clock, 50 MHz
- Reset_n  in  1  asynchronous, active-low reset
- pix_en  in  1  pixel-rate sample enable; one Clk pulse per pixel
- hs  in  1  horizontal sync, active-low, synchronous to Clk
- vs  in  1  vertical sync, active-low, synchronous to Clk
- disp  in  1  high during the visible region
- X  out  10  recovered column, 0..H_VISIBLE-1
- Y  out  10  recovered display line, 0..V_VISIBLE-1
- pixel_valid  out  1  disp & locked, aligned with X/Y
- frame_start  out  1  one-Clk pulse on vs falling edge while locked
- locked  out  1  timing verified
- err_count  out  8  saturating count of lock losses

Behaviour:

General:
- All state updates only on Clk edges with pix_en=1. With pix_en=0 every register holds and frame_start is 0.
- Edge detect uses registered hs_q, vs_q, disp_q, updated on pix_en samples.
  - hs fall = hs_q & ~hs; vs fall = vs_q & ~vs; disp rise = ~disp_q & disp; disp fall = disp_q & ~disp.
- Outputs are registered, so latency is 1 Clk after the qualifying sample.
- Reset (async) clears: X, Y, pixel_valid, frame_start, locked and err_count to 0; state to SEARCH; all counters, seen flags and hs_q/vs_q/disp_q to 1 (sync inactive).

Horizontal:
- h_cnt clears to 0 on hs fall; otherwise increments, saturating at 1023.
- At an hs fall with h_seen=1, line error if h_cnt+1 != H_TOTAL. h_seen then sets.
- X clears to 0 on disp rise and increments on each disp=1 sample thereafter, saturating at 1023.
- At a disp fall, line error if the run length != H_VISIBLE.

Vertical:
- v_cnt increments on each hs fall.
- On vs fall: v_cnt is compared with V_TOTAL, then cleared.
  - A coincident hs fall counts toward the ending frame and is line-checked first.
- Y clears on vs fall and increments on each disp fall, saturating at 1023.
- A frame is good if it contains no line error, v_cnt == V_TOTAL, and the display line count == V_VISIBLE.

FSM (states SEARCH, MEASURE, LOCKED):
- SEARCH:
  - Errors ignored, err_count unchanged.
  - First vs fall -> MEASURE, good = 0.
- MEASURE:
  - At vs fall: good frame -> good+1; bad frame -> good = 0.
  - When good reaches LOCK_FRAMES -> LOCKED, and locked=1 on the next Clk.
- LOCKED:
  - Any line error or bad frame -> MEASURE, good = 0, locked=0 next Clk, err_count+1 (saturates at 255).
  - Line errors raised in MEASURE do not touch err_count.

Outputs:
- pixel_valid = registered (disp & locked-state), where locked-state is the FSM state updated on this same sample.
- frame_start asserts for one Clk on vs fall in LOCKED, including the transition sample into LOCKED.

Boundaries:
- Sync stuck high: no edges, state holds, locked stays as is until the next edge check.
- A sync stuck low has the same behaviour as stuck high.
- Reset mid-line: X/Y return to 0 and lock must be re-earned.

Decomposition:
- Package vga_timing_pkg holds:
  - the default 640x480 constants;
  - typedef enum logic [1:0] {SEARCH, MEASURE, LOCKED} sync_state_t;
  - typedef logic [9:0] coord_t.
- One natural sub-module: sync_edge_det, which registers a strobe under pix_en and emits fall/rise pulses. It is instantiated three times.

Test Plan:
- Nominal 640x480 stimulus at pix_en every 2nd Clk from Reset_n release.
  - locked rises 1 Clk after the third vs-fall sample; err_count=0.
  - frame_start pulses once per 525 lines thereafter.
- Locked, first display sample of the frame -> X=0, Y=0, pixel_valid=1.
  - Last display sample -> X=639, Y=479.
  - Sample after disp falls -> pixel_valid=0.
- Locked, one line shortened to 799 periods -> locked=0 one Clk after that hs fall, err_count=1.
  - Relock after 2 further good frames.
- pix_en held low for 1000 Clk while sync toggles -> X, Y, locked and counters unchanged.
- Reset_n pulsed low mid-frame while locked -> all outputs 0 immediately (async).
  - Relock requires 1 sync vs fall + 2 good frames.
- Frame with 524 lines while locked -> lock lost at that vs fall, err_count increments.
  - 256 induced losses -> err_count stays 255.

Source files
------------

// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg: default 640x480 timing constants and shared
// types for the VGA sync decoder slice.
package vga_timing_pkg;

  localparam int VGA_H_VISIBLE   = 640;
  localparam int VGA_H_TOTAL     = 800;
  localparam int VGA_V_VISIBLE   = 480;
  localparam int VGA_V_TOTAL     = 525;
  localparam int VGA_LOCK_FRAMES = 2;

  typedef enum logic [1:0] {
    SEARCH,
    MEASURE,
    LOCKED
  } sync_state_t;

  typedef logic [9:0] coord_t;

  function automatic coord_t sat_inc(input coord_t v);
    return (v == '1) ? v : coord_t'(v + 10'd1);
  endfunction

endpackage

// File: rtl/vga_sync_decoder_if.sv
// vga_sync_decoder_if: pixel-rate strobe bundle from the VGA
// timing generator (master) to the sync decoder (slave).
interface vga_sync_decoder_if;

  logic pix_en;
  logic hs;
  logic vs;
  logic disp;

  modport master (
    output pix_en,
    output hs,
    output vs,
    output disp
  );

  modport slave (
    input pix_en,
    input hs,
    input vs,
    input disp
  );

endinterface

// File: rtl/sync_edge_det.sv
// sync_edge_det: registers one strobe on pixel enables and flags
// its falling/rising edges on the enabled sample.
module sync_edge_det (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic d,
  output logic fall,
  output logic rise
);

  logic s_q;
  logic s_d;

  // hold the last sampled level between pixel enables
  always_comb begin
    s_d = s_q;
    if (en) s_d = d;
  end

  // sampled level resets to the inactive-high sync level
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) s_q <= 1'b1;
    else        s_q <= s_d;
  end

  assign fall = en & s_q & ~d;
  assign rise = en & ~s_q & d;

endmodule

// File: rtl/vga_sync_decoder.sv
// vga_sync_decoder: rebuilds X/Y, frame markers and a lock
// status from the hs/vs/disp strobes of the VGA controller.
module vga_sync_decoder
  import vga_timing_pkg::*;
#(
  parameter int H_VISIBLE   = VGA_H_VISIBLE,
  parameter int H_TOTAL     = VGA_H_TOTAL,
  parameter int V_VISIBLE   = VGA_V_VISIBLE,
  parameter int V_TOTAL     = VGA_V_TOTAL,
  parameter int LOCK_FRAMES = VGA_LOCK_FRAMES
) (
  input  logic              Clk,
  input  logic              Reset_n,
  vga_sync_decoder_if.slave sync,
  output coord_t            X,
  output coord_t            Y,
  output logic              pixel_valid,
  output logic              frame_start,
  output logic              locked,
  output logic [7:0]        err_count
);

  logic en;
  logic hs_fall;
  logic vs_fall;
  logic disp_fall;
  logic disp_rise;
  logic hs_rise_unused;
  logic vs_rise_unused;

  assign en = sync.pix_en;

  sync_edge_det u_hs_det (
    .clk  (Clk),
    .rst_n(Reset_n),
    .en   (en),
    .d    (sync.hs),
    .fall (hs_fall),
    .rise (hs_rise_unused)
  );

  sync_edge_det u_vs_det (
    .clk  (Clk),
    .rst_n(Reset_n),
    .en   (en),
    .d    (sync.vs),
    .fall (vs_fall),
    .rise (vs_rise_unused)
  );

  sync_edge_det u_disp_det (
    .clk  (Clk),
    .rst_n(Reset_n),
    .en   (en),
    .d    (sync.disp),
    .fall (disp_fall),
    .rise (disp_rise)
  );

  sync_state_t state_q, state_d;
  coord_t      h_cnt_q, h_cnt_d;
  coord_t      v_cnt_q, v_cnt_d;
  coord_t      x_q, x_d;
  coord_t      y_q, y_d;
  logic        h_seen_q, h_seen_d;
  logic        ferr_q, ferr_d;
  logic [7:0]  good_q, good_d;
  logic [7:0]  errs_q, errs_d;
  logic        locked_q, locked_d;
  logic        pv_q, pv_d;
  logic        fs_q, fs_d;

  logic [10:0] h_len;
  logic        h_err;
  logic        d_err;
  logic        line_err;
  coord_t      v_eff;
  coord_t      y_eff;
  logic        frame_ok;

  // line/frame checks and counter updates for this sample
  always_comb begin
    h_len    = {1'b0, h_cnt_q} + 11'd1;
    h_err    = hs_fall & h_seen_q & (h_len != 11'(H_TOTAL));
    d_err    = disp_fall & (x_q != coord_t'(H_VISIBLE - 1));
    line_err = h_err | d_err;
    v_eff    = hs_fall ? sat_inc(v_cnt_q) : v_cnt_q;
    y_eff    = disp_fall ? sat_inc(y_q) : y_q;
    frame_ok = ~ferr_q & ~line_err
             & (v_eff == coord_t'(V_TOTAL))
             & (y_eff == coord_t'(V_VISIBLE));

    h_cnt_d = h_cnt_q;
    if (en) h_cnt_d = hs_fall ? '0 : sat_inc(h_cnt_q);
    h_seen_d = h_seen_q | hs_fall;
    v_cnt_d  = vs_fall ? '0 : v_eff;
    ferr_d   = vs_fall ? 1'b0 : (ferr_q | line_err);

    x_d = x_q;
    if (disp_rise)          x_d = '0;
    else if (en & sync.disp) x_d = sat_inc(x_q);
    y_d = vs_fall ? '0 : y_eff;
  end

  // lock state machine and registered status outputs
  always_comb begin
    state_d = state_q;
    good_d  = good_q;
    errs_d  = errs_q;
    unique case (state_q)
      SEARCH: begin
        if (vs_fall) begin
          state_d = MEASURE;
          good_d  = '0;
        end
      end
      MEASURE: begin
        if (vs_fall) begin
          if (frame_ok) begin
            good_d = good_q + 8'd1;
            if (good_d == 8'(LOCK_FRAMES)) state_d = LOCKED;
          end else begin
            good_d = '0;
          end
        end
      end
      LOCKED: begin
        if (line_err | (vs_fall & ~frame_ok)) begin
          state_d = MEASURE;
          good_d  = '0;
          if (errs_q != 8'hff) errs_d = errs_q + 8'd1;
        end
      end
      default: state_d = SEARCH;
    endcase
    locked_d = (state_d == LOCKED);
    pv_d     = pv_q;
    if (en) pv_d = sync.disp & locked_d;
    fs_d     = vs_fall & locked_d;
  end

  // all decoder state, counters start at 1 and syncs inactive
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q  <= SEARCH;
      h_cnt_q  <= coord_t'(1);
      v_cnt_q  <= coord_t'(1);
      h_seen_q <= 1'b1;
      ferr_q   <= 1'b0;
      good_q   <= '0;
      errs_q   <= '0;
      x_q      <= '0;
      y_q      <= '0;
      locked_q <= 1'b0;
      pv_q     <= 1'b0;
      fs_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      h_cnt_q  <= h_cnt_d;
      v_cnt_q  <= v_cnt_d;
      h_seen_q <= h_seen_d;
      ferr_q   <= ferr_d;
      good_q   <= good_d;
      errs_q   <= errs_d;
      x_q      <= x_d;
      y_q      <= y_d;
      locked_q <= locked_d;
      pv_q     <= pv_d;
      fs_q     <= fs_d;
    end
  end

  assign X           = x_q;
  assign Y           = y_q;
  assign pixel_valid = pv_q;
  assign frame_start = fs_q;
  assign locked      = locked_q;
  assign err_count   = errs_q;

endmodule
